// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED sequencer.
//   state_t     - sequencer FSM states
//   MODE_*      - i_sw[1:0] mode codes
//   SEED_*      - pattern loaded on a mode change or illegal pattern
//   helpers     - mode/state/seed mapping and pattern legality
package led_seq_pkg;

  localparam int LED_W = 4;

  typedef enum logic [2:0] {
    S_LEFT,
    S_RIGHT,
    S_PP_UP,
    S_PP_DOWN,
    S_FLASH
  } state_t;

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_PP    = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  localparam logic [LED_W-1:0] SEED_WALK  = 4'b0001;
  localparam logic [LED_W-1:0] SEED_FLASH = 4'b1111;

  // Mode implied by a state; both ping-pong directions are one mode.
  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      S_RIGHT:             return MODE_RIGHT;
      S_PP_UP, S_PP_DOWN:  return MODE_PP;
      S_FLASH:             return MODE_FLASH;
      default:             return MODE_LEFT;
    endcase
  endfunction

  // State entered when a mode is (re)seeded; ping-pong always starts upward.
  function automatic state_t seed_state(input logic [1:0] m);
    case (m)
      MODE_RIGHT: return S_RIGHT;
      MODE_PP:    return S_PP_UP;
      MODE_FLASH: return S_FLASH;
      default:    return S_LEFT;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] seed_pat(input logic [1:0] m);
    return (m == MODE_FLASH) ? SEED_FLASH : SEED_WALK;
  endfunction

  // Walking modes need exactly one lit LED; flash needs all-on or all-off.
  function automatic logic pat_legal(input logic [1:0] m, input logic [LED_W-1:0] p);
    if (m == MODE_FLASH) return (p == SEED_FLASH) || (p == '0);
    return (p != '0) && ((p & (p - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/led_sequencer.sv
// led_sequencer: steps a 4-bit LED pattern (rotate left/right, ping-pong,
// flash) once per enabled i_valid strobe.
//   clock    - system clock, rising edge
//   i_reset  - asynchronous active-high reset
//   i_valid  - step strobe from the count block
//   i_sw     - [1:0] mode, [2] run enable, [3] colour select
//   o_led    - current pattern (the pattern register itself)
//   o_led_g  - pattern when registered colour select is 0, else 0
//   o_led_b  - pattern when registered colour select is 1, else 0
//   o_wrap   - one-cycle pulse after the step that completes a cycle
module led_sequencer
  import led_seq_pkg::*;
(
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [3:0]       i_sw,
  output logic [LED_W-1:0] o_led,
  output logic [LED_W-1:0] o_led_g,
  output logic [LED_W-1:0] o_led_b,
  output logic             o_wrap
);

  state_t           state, state_nx;
  logic [LED_W-1:0] pat, pat_nx;
  logic             wrap, wrap_nx;
  logic             sel;
  logic             rst_q;   // high until the first edge after reset release
  logic             vld_q;   // i_valid as seen at the previous edge
  logic             step;

  // i_valid held high through reset is stale; swallow it on the first
  // edge after release.
  assign step = i_valid & i_sw[2] & ~(rst_q & vld_q);

  always_comb begin
    state_nx = state;
    pat_nx   = pat;
    wrap_nx  = 1'b0;
    if ((i_sw[1:0] != mode_of(state)) || !pat_legal(i_sw[1:0], pat)) begin
      state_nx = seed_state(i_sw[1:0]);
      pat_nx   = seed_pat(i_sw[1:0]);
    end else begin
      case (state)
        S_LEFT: begin
          pat_nx  = {pat[LED_W-2:0], pat[LED_W-1]};
          wrap_nx = pat[LED_W-1];
        end
        S_RIGHT: begin
          pat_nx  = {pat[0], pat[LED_W-1:1]};
          wrap_nx = pat[0];
        end
        // Direction flips on the step leaving an end, so the end value
        // is shown for exactly one step.
        S_PP_UP: begin
          if (pat[LED_W-1]) begin
            pat_nx   = {1'b0, pat[LED_W-1:1]};
            state_nx = S_PP_DOWN;
          end else begin
            pat_nx = {pat[LED_W-2:0], 1'b0};
          end
        end
        S_PP_DOWN: begin
          if (pat[0]) begin
            pat_nx   = {pat[LED_W-2:0], 1'b0};
            state_nx = S_PP_UP;
          end else begin
            pat_nx  = {1'b0, pat[LED_W-1:1]};
            wrap_nx = pat[1];
          end
        end
        S_FLASH: begin
          pat_nx  = ~pat;
          wrap_nx = (pat == SEED_FLASH);
        end
        default: begin
          state_nx = S_LEFT;
          pat_nx   = SEED_WALK;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state <= S_LEFT;
      pat   <= SEED_WALK;
      sel   <= 1'b0;
      wrap  <= 1'b0;
      rst_q <= 1'b1;
    end else begin
      sel   <= i_sw[3];
      rst_q <= 1'b0;
      wrap  <= 1'b0;
      if (step) begin
        state <= state_nx;
        pat   <= pat_nx;
        wrap  <= wrap_nx;
      end
    end
  end

  // Plain sample of the strobe; it must keep tracking i_valid during reset.
  always_ff @(posedge clock) vld_q <= i_valid;

  assign o_led   = pat;
  assign o_led_g = sel ? '0 : pat;
  assign o_led_b = sel ? pat : '0;
  assign o_wrap  = wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed scenarios plus a randomized run checked against
// a position/sequence-table model of the LED sequencer.
module tb_led_sequencer;

  logic       clock = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic [3:0] i_sw;
  logic [3:0] o_led, o_led_g, o_led_b;
  logic       o_wrap;

  int checks = 0;
  int failures = 0;

  led_sequencer dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_sw    (i_sw),
    .o_led   (o_led),
    .o_led_g (o_led_g),
    .o_led_b (o_led_b),
    .o_wrap  (o_wrap)
  );

  always #5 clock = ~clock;

  // Reference model: mode number, lit-LED index for rotations, position in
  // the six-entry ping-pong sequence, on/off for flash.
  int   m_mode, m_idx, m_pos;
  bit   m_on, m_wrap, m_sel, m_after_rst, m_vld_last;
  logic [3:0] pp_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

  function automatic logic [3:0] model_led();
    case (m_mode)
      0, 1:    return 4'(1 << m_idx);
      2:       return pp_tab[m_pos];
      default: return m_on ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_pos = 0; m_on = 1'b1;
    m_wrap = 1'b0; m_sel = 1'b0; m_after_rst = 1'b1;
  endtask

  task automatic model_step();
    int sm;
    sm = int'(i_sw[1:0]);
    if (sm != m_mode) begin
      m_mode = sm; m_idx = 0; m_pos = 0; m_on = 1'b1;
    end else begin
      case (m_mode)
        0: begin m_idx = (m_idx + 1) % 4; m_wrap = (m_idx == 0); end
        1: begin m_idx = (m_idx + 3) % 4; m_wrap = (m_idx == 3); end
        2: begin m_pos = (m_pos + 1) % 6; m_wrap = (m_pos == 0); end
        default: begin m_on = !m_on; m_wrap = !m_on; end
      endcase
    end
  endtask

  // One clock: update the model from the inputs at the edge, then settle.
  task automatic tick();
    bit blocked;
    @(posedge clock);
    m_wrap = 1'b0;
    if (i_reset) begin
      m_after_rst = 1'b1;
      m_vld_last  = i_valid;
    end else begin
      blocked     = m_after_rst && m_vld_last;
      m_after_rst = 1'b0;
      m_vld_last  = i_valid;
      m_sel       = i_sw[3];
      if (i_valid && i_sw[2] && !blocked) model_step();
    end
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_sw = 4'b0000;
    model_reset();
    repeat (3) tick();
    checks++; if (o_led !== 4'b0001) begin failures++; $display("FAIL reset_led got=%b want=0001", o_led); end
    checks++; if (o_led_g !== 4'b0001) begin failures++; $display("FAIL reset_led_g got=%b want=0001", o_led_g); end
    checks++; if (o_led_b !== 4'b0000) begin failures++; $display("FAIL reset_led_b got=%b want=0000", o_led_b); end
    checks++; if (o_wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b want=0", o_wrap); end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_rotate_left();
    logic [3:0] exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic       wex [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      i_sw = 4'b0100; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      checks++; if (o_led !== exp[i]) begin failures++; $display("FAIL rotl_led[%0d] got=%b want=%b", i, o_led, exp[i]); end
      checks++; if (o_wrap !== wex[i]) begin failures++; $display("FAIL rotl_wrap[%0d] got=%b want=%b", i, o_wrap, wex[i]); end
      tick();
      checks++; if (o_wrap !== 1'b0) begin failures++; $display("FAIL rotl_wrap_idle[%0d] got=%b want=0", i, o_wrap); end
    end
  endtask

  task automatic test_pingpong();
    logic [3:0] exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      i_sw = 4'b0110; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      checks++; if (o_led !== exp[i]) begin failures++; $display("FAIL pp_led[%0d] got=%b want=%b", i, o_led, exp[i]); end
      checks++; if (o_wrap !== (i == 6)) begin failures++; $display("FAIL pp_wrap[%0d] got=%b want=%b", i, o_wrap, (i == 6)); end
      tick();
    end
  endtask

  task automatic test_flash();
    logic [3:0] exp [3] = '{4'b1111, 4'b0000, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      i_sw = 4'b0111; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      checks++; if (o_led !== exp[i]) begin failures++; $display("FAIL flash_led[%0d] got=%b want=%b", i, o_led, exp[i]); end
      checks++; if (o_wrap !== (i == 1)) begin failures++; $display("FAIL flash_wrap[%0d] got=%b want=%b", i, o_wrap, (i == 1)); end
      tick();
    end
  endtask

  task automatic test_hold_colour();
    i_sw = 4'b0000; i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (o_led !== 4'b1111) begin failures++; $display("FAIL hold_led[%0d] got=%b want=1111", i, o_led); end
      checks++; if (o_wrap !== 1'b0) begin failures++; $display("FAIL hold_wrap[%0d] got=%b want=0", i, o_wrap); end
    end
    i_valid = 1'b0; i_sw = 4'b1000;
    #1;
    checks++; if (o_led_b !== 4'b0000) begin failures++; $display("FAIL colour_pre_b got=%b want=0000", o_led_b); end
    tick();
    checks++; if (o_led_b !== 4'b1111) begin failures++; $display("FAIL colour_b got=%b want=1111", o_led_b); end
    checks++; if (o_led_g !== 4'b0000) begin failures++; $display("FAIL colour_g got=%b want=0000", o_led_g); end
    i_sw = 4'b0000;
    tick();
  endtask

  // Valid held high: one step per cycle (seed load, then rotate right).
  task automatic test_back_to_back();
    logic [3:0] exp [6] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic       wex [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    i_sw = 4'b0101; i_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (o_led !== exp[i]) begin failures++; $display("FAIL b2b_led[%0d] got=%b want=%b", i, o_led, exp[i]); end
      checks++; if (o_wrap !== wex[i]) begin failures++; $display("FAIL b2b_wrap[%0d] got=%b want=%b", i, o_wrap, wex[i]); end
    end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      i_sw = 4'b0100; i_valid = 1'b1; tick(); i_valid = 1'b0; tick();
    end
    checks++; if (o_led !== 4'b0100) begin failures++; $display("FAIL areset_pre got=%b want=0100", o_led); end
    #2;
    i_reset = 1'b1;
    model_reset();
    #1;
    checks++; if (o_led !== 4'b0001) begin failures++; $display("FAIL areset_led got=%b want=0001", o_led); end
    checks++; if (o_led_g !== 4'b0001) begin failures++; $display("FAIL areset_led_g got=%b want=0001", o_led_g); end
    checks++; if (o_wrap !== 1'b0) begin failures++; $display("FAIL areset_wrap got=%b want=0", o_wrap); end
    repeat (2) tick();
    i_reset = 1'b0;
    tick();
    i_valid = 1'b1; tick(); i_valid = 1'b0;
    checks++; if (o_led !== 4'b0010) begin failures++; $display("FAIL areset_step got=%b want=0010", o_led); end
    tick();
  endtask

  task automatic test_reset_valid_high();
    i_reset = 1'b1; i_sw = 4'b0100; i_valid = 1'b1;
    model_reset();
    repeat (2) tick();
    i_reset = 1'b0;
    tick();
    checks++; if (o_led !== 4'b0001) begin failures++; $display("FAIL rstvld_first got=%b want=0001", o_led); end
    tick();
    checks++; if (o_led !== 4'b0010) begin failures++; $display("FAIL rstvld_second got=%b want=0010", o_led); end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] mode;
    logic [3:0] el;
    mode = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      i_sw    = {1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), mode};
      i_valid = 1'($urandom_range(0, 1));
      if (i_reset) i_reset = 1'b0;
      else if ($urandom_range(0, 63) == 0) begin
        i_reset = 1'b1;
        model_reset();
      end
      tick();
      el = model_led();
      checks++; if (o_led !== el) begin failures++; $display("FAIL rnd_led[%0d] got=%b want=%b", i, o_led, el); end
      checks++; if (o_led_g !== (m_sel ? 4'b0000 : el)) begin failures++; $display("FAIL rnd_led_g[%0d] got=%b want=%b", i, o_led_g, (m_sel ? 4'b0000 : el)); end
      checks++; if (o_led_b !== (m_sel ? el : 4'b0000)) begin failures++; $display("FAIL rnd_led_b[%0d] got=%b want=%b", i, o_led_b, (m_sel ? el : 4'b0000)); end
      checks++; if (o_wrap !== m_wrap) begin failures++; $display("FAIL rnd_wrap[%0d] got=%b want=%b", i, o_wrap, m_wrap); end
    end
    i_reset = 1'b0; i_valid = 1'b0;
  endtask

  initial begin
    m_vld_last = 1'b0;
    test_reset();
    test_rotate_left();
    test_pingpong();
    test_flash();
    test_hold_colour();
    test_back_to_back();
    test_async_reset();
    test_reset_valid_high();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
